control_unit: RTL and testbench

Multi-cycle fetch/decode/execute/writeback sequencer for the RV32I subset run by the Fibonacci core. It sits directly upstream of the `alu`. It fetches instructions over a valid-handshake instruction port and reads the register file. It drives the ALU operands and `alucontrol`, then consumes `reg_destiny`/`zero` for writeback and branch resolution.

---
 rtl/control_unit_if.sv | 24 ++
 rtl/control_unit.sv | 156 +++++++++++++++
 tb/tb_control_unit.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_unit_if.sv
// Instruction-fetch bus between the sequencer (master) and instruction memory (slave).
// The request stays high while the sequencer waits; valid qualifies the returned word.
interface control_unit_if #(
  parameter int N = 32
);
  logic         imem_req;
  logic [N-1:0] imem_addr;
  logic [31:0]  imem_rdata;
  logic         imem_valid;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_valid
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_valid
  );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the ADD/SUB/ADDI/BEQ/BNE subset.
// The ALU and register file live outside; this block drives their operands and write strobe.
module control_unit #(
  parameter int           N        = 32,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  control_unit_if.master imem,
  output logic [4:0]     rs1_addr,
  output logic [4:0]     rs2_addr,
  input  logic [N-1:0]   rs1_data,
  input  logic [N-1:0]   rs2_data,
  output logic           rf_we,
  output logic [4:0]     rd_addr,
  output logic [N-1:0]   rd_wdata,
  output logic [N-1:0]   alu_a,
  output logic [N-1:0]   alu_b,
  output logic [3:0]     alucontrol,
  input  logic [N-1:0]   alu_result,
  input  logic           alu_zero,
  output logic [N-1:0]   pc,
  output logic           halted,
  output logic           illegal,
  output logic [31:0]    retired
);
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;

  typedef enum logic [2:0] {
    S_BOOT, S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_HALT
  } state_t;

  state_t       state_q;
  logic [N-1:0] pc_q, a_q, b_q, result_q, target_q;
  logic [31:0]  ir_q, retired_q;
  logic [3:0]   alucontrol_q;
  logic         imem_req_q, rf_we_q, halted_q, illegal_q;

  logic [6:0]   opcode_d, funct7_d;
  logic [2:0]   funct3_d;
  logic         is_add_d, is_sub_d, is_addi_d, is_br_d, is_sys_d, br_taken_d;
  logic [N-1:0] imm_i_d, imm_b_d, pc_plus4_d, target_d;

  // IR is held from FETCH exit until the next fetch, so decode stays valid through EXECUTE.
  assign opcode_d   = ir_q[6:0];
  assign funct3_d   = ir_q[14:12];
  assign funct7_d   = ir_q[31:25];
  assign is_add_d   = (opcode_d == 7'b0110011) && (funct3_d == 3'b000) && (funct7_d == 7'b0000000);
  assign is_sub_d   = (opcode_d == 7'b0110011) && (funct3_d == 3'b000) && (funct7_d == 7'b0100000);
  assign is_addi_d  = (opcode_d == 7'b0010011) && (funct3_d == 3'b000);
  assign is_br_d    = (opcode_d == 7'b1100011) && ((funct3_d == 3'b000) || (funct3_d == 3'b001));
  assign is_sys_d   = (ir_q == 32'h0010_0073) || (ir_q == 32'h0000_0073);
  assign imm_i_d    = {{(N-12){ir_q[31]}}, ir_q[31:20]};
  assign imm_b_d    = {{(N-12){ir_q[31]}}, ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign pc_plus4_d = pc_q + N'(4);
  assign target_d   = pc_q + imm_b_d;
  // funct3[0] distinguishes BNE from BEQ.
  assign br_taken_d = ir_q[12] ? ~alu_zero : alu_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_PC;
      ir_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      result_q     <= '0;
      target_q     <= '0;
      retired_q    <= '0;
      alucontrol_q <= ALU_ADD;
      imem_req_q   <= 1'b0;
      rf_we_q      <= 1'b0;
      halted_q     <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      imem_req_q <= 1'b0;
      rf_we_q    <= 1'b0;
      case (state_q)
        S_BOOT: begin
          state_q    <= S_FETCH;
          imem_req_q <= 1'b1;
        end
        S_FETCH: begin
          if (imem.imem_valid) begin
            ir_q    <= imem.imem_rdata;
            state_q <= S_DECODE;
          end else begin
            imem_req_q <= 1'b1;
          end
        end
        S_DECODE: begin
          a_q      <= rs1_data;
          b_q      <= is_addi_d ? imm_i_d : rs2_data;
          target_q <= target_d;
          if (is_sys_d) begin
            retired_q <= retired_q + 32'd1;
            halted_q  <= 1'b1;
            state_q   <= S_HALT;
          end else if (is_add_d || is_addi_d) begin
            alucontrol_q <= ALU_ADD;
            state_q      <= S_EXECUTE;
          end else if (is_sub_d || is_br_d) begin
            alucontrol_q <= ALU_SUB;
            state_q      <= S_EXECUTE;
          end else begin
            illegal_q <= 1'b1;
            halted_q  <= 1'b1;
            state_q   <= S_HALT;
          end
        end
        S_EXECUTE: begin
          result_q <= alu_result;
          if (is_br_d) begin
            if (br_taken_d && (target_q[1:0] != 2'b00)) begin
              illegal_q <= 1'b1;
              halted_q  <= 1'b1;
              state_q   <= S_HALT;
            end else begin
              pc_q       <= br_taken_d ? target_q : pc_plus4_d;
              retired_q  <= retired_q + 32'd1;
              state_q    <= S_FETCH;
              imem_req_q <= 1'b1;
            end
          end else begin
            rf_we_q <= (ir_q[11:7] != 5'd0);
            state_q <= S_WRITEBACK;
          end
        end
        S_WRITEBACK: begin
          pc_q       <= pc_plus4_d;
          retired_q  <= retired_q + 32'd1;
          state_q    <= S_FETCH;
          imem_req_q <= 1'b1;
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_HALT;
      endcase
    end
  end

  assign imem.imem_req  = imem_req_q;
  assign imem.imem_addr = pc_q;
  assign rs1_addr       = ir_q[19:15];
  assign rs2_addr       = ir_q[24:20];
  assign rd_addr        = ir_q[11:7];
  assign rf_we          = rf_we_q;
  assign rd_wdata       = result_q;
  assign alu_a          = a_q;
  assign alu_b          = b_q;
  assign alucontrol     = alucontrol_q;
  assign pc             = pc_q;
  assign halted         = halted_q;
  assign illegal        = illegal_q;
  assign retired        = retired_q;
endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: models instruction memory, register file and ALU around the DUT,
// then checks directed vectors, halt/reset corner cases and a randomized program.
`timescale 1ns/1ps
module tb_control_unit;
  localparam int N = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  control_unit_if #(.N(N)) ibus ();

  logic [4:0]   rs1_addr, rs2_addr, rd_addr;
  logic [N-1:0] rs1_data, rs2_data, rd_wdata, alu_a, alu_b, alu_result, pc;
  logic         rf_we, alu_zero, halted, illegal;
  logic [3:0]   alucontrol;
  logic [31:0]  retired;

  control_unit #(.N(N), .RESET_PC(32'h0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem       (ibus),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .rf_we      (rf_we),
    .rd_addr    (rd_addr),
    .rd_wdata   (rd_wdata),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alucontrol (alucontrol),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .pc         (pc),
    .halted     (halted),
    .illegal    (illegal),
    .retired    (retired)
  );

  // Environment: register file, ALU with optional forced zero flag, write monitor.
  logic [N-1:0] rf [32];
  logic         pre_we = 1'b0;
  logic [4:0]   pre_a = '0;
  logic [N-1:0] pre_v = '0;
  logic [1:0]   zmode = 2'd0;
  int           wr_cnt = 0;
  logic [4:0]   wr_a = '0;
  logic [N-1:0] wr_d = '0;

  assign rs1_data   = (rs1_addr == 5'd0) ? '0 : rf[rs1_addr];
  assign rs2_data   = (rs2_addr == 5'd0) ? '0 : rf[rs2_addr];
  assign alu_result = (alucontrol == 4'b0001) ? (alu_a - alu_b) : (alu_a + alu_b);
  assign alu_zero   = (zmode == 2'd1) ? 1'b1 : (zmode == 2'd2) ? 1'b0 : (alu_result == '0);

  always @(posedge clk) begin
    if (pre_we) rf[pre_a] <= pre_v;
    else if (rf_we && rd_addr != 5'd0) rf[rd_addr] <= rd_wdata;
    if (rf_we) begin
      wr_cnt <= wr_cnt + 1;
      wr_a   <= rd_addr;
      wr_d   <= rd_wdata;
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preset(input logic [4:0] a, input logic [31:0] v);
    pre_a = a; pre_v = v; pre_we = 1'b1;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic do_reset(input bit check);
    rst_n = 1'b0;
    ibus.imem_valid = 1'b0;
    ibus.imem_rdata = '0;
    zmode = 2'd0;
    #1;
    if (check) begin
      chk("rst_imem_req", {31'b0, ibus.imem_req}, 32'd0);
      chk("rst_rf_we", {31'b0, rf_we}, 32'd0);
      chk("rst_halted", {31'b0, halted}, 32'd0);
      chk("rst_illegal", {31'b0, illegal}, 32'd0);
      chk("rst_pc", pc, 32'h0);
      chk("rst_retired", retired, 32'd0);
      chk("rst_alucontrol", {28'b0, alucontrol}, 32'd0);
      chk("rst_alu_a", alu_a, 32'd0);
      chk("rst_alu_b", alu_b, 32'd0);
      chk("rst_rd_wdata", rd_wdata, 32'd0);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic exec(input logic [31:0] ins, output int cyc, output int nwr);
    int k;
    int w0;
    k = 0;
    while (!ibus.imem_req && k < 50) begin tick(); k++; end
    chk("fetch_req_seen", {31'b0, ibus.imem_req}, 32'd1);
    w0 = wr_cnt;
    ibus.imem_rdata = ins;
    ibus.imem_valid = 1'b1;
    tick();
    ibus.imem_valid = 1'b0;
    cyc = 1;
    while (!ibus.imem_req && !halted && cyc < 50) begin tick(); cyc++; end
    nwr = wr_cnt - w0;
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [4:0]  pa1; logic [31:0] pv1;
    logic [4:0]  pa2; logic [31:0] pv2;
    logic [1:0]  zm;
    int          cyc;
    int          nwr;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] pc;
    logic [31:0] ret;
  } vec_t;

  vec_t vecs [9];

  // Reference model state for the randomized program.
  logic [31:0] m_rf [32];
  logic [31:0] m_pc, m_ret, ins, ev, ov;
  logic [4:0]  rd, r1, r2;
  logic [11:0] imm12;
  int          t, off, simm, cyc, nwr, ecyc, enwr, w0;
  bit          taken;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h0050_0093, 5'd0, 32'd0, 5'd0, 32'd0, 2'd0, 4, 1, 5'd1, 32'd5, 32'h04, 32'd1};
    vecs[1] = '{32'h0020_81B3, 5'd1, 32'd8, 5'd2, 32'd13, 2'd0, 4, 1, 5'd3, 32'd21, 32'h08, 32'd2};
    vecs[2] = '{32'h4020_81B3, 5'd1, 32'd8, 5'd2, 32'd13, 2'd0, 4, 1, 5'd3, 32'hFFFF_FFFB, 32'h0C, 32'd3};
    vecs[3] = '{32'h0070_0013, 5'd0, 32'd0, 5'd0, 32'd0, 2'd0, 4, 0, 5'd0, 32'd0, 32'h10, 32'd4};
    vecs[4] = '{32'h0000_0463, 5'd0, 32'd0, 5'd0, 32'd0, 2'd2, 3, 0, 5'd0, 32'd0, 32'h14, 32'd5};
    vecs[5] = '{32'h0000_0463, 5'd0, 32'd0, 5'd0, 32'd0, 2'd1, 3, 0, 5'd0, 32'd0, 32'h1C, 32'd6};
    vecs[6] = '{32'h0010_1463, 5'd1, 32'd8, 5'd0, 32'd0, 2'd0, 3, 0, 5'd0, 32'd0, 32'h24, 32'd7};
    vecs[7] = '{32'hFE00_0CE3, 5'd0, 32'd0, 5'd0, 32'd0, 2'd0, 3, 0, 5'd0, 32'd0, 32'h1C, 32'd8};
    vecs[8] = '{32'hFFF0_0F93, 5'd0, 32'd0, 5'd0, 32'd0, 2'd0, 4, 1, 5'd31, 32'hFFFF_FFFF, 32'h20, 32'd9};

    do_reset(1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_req", {31'b0, ibus.imem_req}, 32'd1);
      chk("stall_addr", ibus.imem_addr, 32'h0);
      chk("stall_retired", retired, 32'd0);
      tick();
    end

    foreach (vecs[i]) begin
      if (vecs[i].pa1 != 5'd0) preset(vecs[i].pa1, vecs[i].pv1);
      if (vecs[i].pa2 != 5'd0) preset(vecs[i].pa2, vecs[i].pv2);
      zmode = vecs[i].zm;
      exec(vecs[i].ins, cyc, nwr);
      zmode = 2'd0;
      $display("vec %0d ins=%h cyc=%0d wr=%0d pc=%h retired=%0d", i, vecs[i].ins, cyc, nwr, pc, retired);
      chk("vec_cycles", cyc, vecs[i].cyc);
      chk("vec_writes", nwr, vecs[i].nwr);
      if (vecs[i].nwr != 0) begin
        chk("vec_rd_addr", {27'b0, wr_a}, {27'b0, vecs[i].wa});
        chk("vec_rd_wdata", wr_d, vecs[i].wd);
      end
      chk("vec_pc", pc, vecs[i].pc);
      chk("vec_retired", retired, vecs[i].ret);
      chk("vec_halted", {31'b0, halted}, 32'd0);
    end

    // Stalled fetch at a nonzero pc keeps the address steady.
    for (int i = 0; i < 3; i++) begin
      chk("stall2_addr", ibus.imem_addr, 32'h20);
      tick();
    end

    // Asynchronous reset mid-cycle, then an illegal word.
    #3;
    do_reset(1'b1);
    exec(32'hFFFF_FFFF, cyc, nwr);
    $display("illegal ins=ffffffff cyc=%0d halted=%0d illegal=%0d", cyc, halted, illegal);
    chk("ill_illegal", {31'b0, illegal}, 32'd1);
    chk("ill_halted", {31'b0, halted}, 32'd1);
    chk("ill_retired", retired, 32'd0);
    ibus.imem_rdata = 32'h0050_0093;
    ibus.imem_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ill_stay_halted", {31'b0, halted}, 32'd1);
      chk("ill_no_req", {31'b0, ibus.imem_req}, 32'd0);
      chk("ill_no_we", {31'b0, rf_we}, 32'd0);
    end
    chk("ill_pc_hold", pc, 32'h0);

    do_reset(1'b1);
    exec(32'h0010_0073, cyc, nwr);
    $display("ebreak cyc=%0d halted=%0d illegal=%0d retired=%0d", cyc, halted, illegal, retired);
    chk("ebreak_cycles", cyc, 32'd2);
    chk("ebreak_halted", {31'b0, halted}, 32'd1);
    chk("ebreak_illegal", {31'b0, illegal}, 32'd0);
    chk("ebreak_retired", retired, 32'd1);
    chk("ebreak_pc", pc, 32'h0);
    tick(); tick(); tick();
    chk("ebreak_stay", {31'b0, halted}, 32'd1);
    chk("ebreak_no_req", {31'b0, ibus.imem_req}, 32'd0);

    do_reset(1'b0);
    exec(32'h0000_0073, cyc, nwr);
    $display("ecall cyc=%0d halted=%0d retired=%0d", cyc, halted, retired);
    chk("ecall_halted", {31'b0, halted}, 32'd1);
    chk("ecall_retired", retired, 32'd1);

    // Taken branch to pc+2 is misaligned.
    do_reset(1'b0);
    exec(32'h0000_0163, cyc, nwr);
    $display("misaligned cyc=%0d halted=%0d illegal=%0d pc=%h", cyc, halted, illegal, pc);
    chk("mis_cycles", cyc, 32'd3);
    chk("mis_illegal", {31'b0, illegal}, 32'd1);
    chk("mis_halted", {31'b0, halted}, 32'd1);
    chk("mis_pc", pc, 32'h0);
    chk("mis_retired", retired, 32'd0);

    // Reset during EXECUTE must prevent the pending write.
    do_reset(1'b0);
    w0 = wr_cnt;
    ibus.imem_rdata = 32'h0090_0293;
    ibus.imem_valid = 1'b1;
    tick();
    ibus.imem_valid = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_we", {31'b0, rf_we}, 32'd0);
    tick(); tick();
    chk("abort_writes", wr_cnt - w0, 32'd0);
    chk("abort_pc", pc, 32'h0);
    $display("abort writes=%0d pc=%h", wr_cnt - w0, pc);

    // Randomized program against an instruction-level model.
    do_reset(1'b0);
    m_rf[0] = '0;
    for (int i = 1; i < 32; i++) begin
      m_rf[i] = $urandom;
      preset(5'(i), m_rf[i]);
    end
    m_pc = 32'h0;
    m_ret = 32'd0;
    for (int i = 0; i < 150; i++) begin
      t  = int'($urandom_range(0, 4));
      rd = 5'($urandom);
      if (t >= 3) begin
        r1 = 5'($urandom_range(0, 3));
        r2 = 5'($urandom_range(0, 3));
      end else begin
        r1 = 5'($urandom);
        r2 = 5'($urandom);
      end
      ev = '0;
      enwr = 0;
      if (t <= 1) begin
        ins = {(t == 1) ? 7'b0100000 : 7'b0000000, r2, r1, 3'b000, rd, 7'b0110011};
        ev = (t == 1) ? (m_rf[r1] - m_rf[r2]) : (m_rf[r1] + m_rf[r2]);
        ecyc = 4;
      end else if (t == 2) begin
        simm = int'($urandom_range(0, 4095)) - 2048;
        imm12 = 12'(simm);
        ins = {imm12, r1, 3'b000, rd, 7'b0010011};
        ev = m_rf[r1] + 32'(simm);
        ecyc = 4;
      end else begin
        off = (int'($urandom_range(0, 255)) - 128) * 4;
        ov = 32'(off);
        ins = {ov[12], ov[10:5], r2, r1, 2'b00, 1'(t == 4), ov[4:1], ov[11], 7'b1100011};
        ecyc = 3;
      end
      if (t <= 2) begin
        enwr = (rd != 5'd0) ? 1 : 0;
        if (rd != 5'd0) m_rf[rd] = ev;
        m_pc = m_pc + 32'd4;
      end else begin
        taken = (m_rf[r1] == m_rf[r2]) ^ (t == 4);
        m_pc = taken ? m_pc + 32'(off) : m_pc + 32'd4;
      end
      m_ret = m_ret + 32'd1;
      exec(ins, cyc, nwr);
      $display("rand %0d ins=%h cyc=%0d wr=%0d pc=%h retired=%0d", i, ins, cyc, nwr, pc, retired);
      chk("rand_cycles", cyc, ecyc);
      chk("rand_writes", nwr, enwr);
      if (enwr != 0) begin
        chk("rand_rd_addr", {27'b0, wr_a}, {27'b0, rd});
        chk("rand_rd_wdata", wr_d, ev);
      end
      chk("rand_pc", pc, m_pc);
      chk("rand_imem_addr", ibus.imem_addr, m_pc);
      chk("rand_retired", retired, m_ret);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
